he_lut_remap: RTL and testbench

HE_LUT_REMAP -- requirements
Module: he_lut_remap

---
 rtl/he_lut_remap_if.sv | 60 ++++++
 rtl/he_lut_remap.sv | 185 ++++++++++++++++++
 tb/tb_he_lut_remap.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/he_lut_remap_if.sv
// -----------------------------------------------------------------------------
// he_lut_remap_if
//
// Purpose : Bundles the table-load stream, the source-pixel stream and the
//           remapped-pixel output stream of he_lut_remap into one interface.
//
// Signals :
//   tbl_valid        table entry present on tbl_data
//   tbl_data  [7:0]  transformation-table entry, index order 0..255
//   pixel_valid      source pixel present on pixel_in
//   pixel_in  [7:0]  source pixel value (LUT address)
//   ready            high while the remapper is mapping pixels
//   pixel_out_valid  remapped pixel present on pixel_out
//   pixel_out [7:0]  remapped pixel value
//   line_end         pulse with the last output pixel of a line
//   frame_done       pulse with the last output pixel of a frame
//   mono_err         sticky table-monotonicity error
//
// Modports:
//   master  producer of tables/pixels, consumer of the remapped stream
//   slave   the remapper itself
// -----------------------------------------------------------------------------
interface he_lut_remap_if;
  logic       tbl_valid;
  logic [7:0] tbl_data;
  logic       pixel_valid;
  logic [7:0] pixel_in;
  logic       ready;
  logic       pixel_out_valid;
  logic [7:0] pixel_out;
  logic       line_end;
  logic       frame_done;
  logic       mono_err;

  modport master (
    output tbl_valid,
    output tbl_data,
    output pixel_valid,
    output pixel_in,
    input  ready,
    input  pixel_out_valid,
    input  pixel_out,
    input  line_end,
    input  frame_done,
    input  mono_err
  );

  modport slave (
    input  tbl_valid,
    input  tbl_data,
    input  pixel_valid,
    input  pixel_in,
    output ready,
    output pixel_out_valid,
    output pixel_out,
    output line_end,
    output frame_done,
    output mono_err
  );
endinterface

// File: rtl/he_lut_remap.sv
// -----------------------------------------------------------------------------
// he_lut_remap
//
// Purpose : Histogram-equalisation remapper. A 256-entry transformation table
//           is streamed in (entries 0..255, gaps allowed), then every source
//           pixel of one frame is replaced by LUT[pixel] with one cycle of
//           latency. After the last pixel of a frame the block returns to IDLE
//           and waits for a complete new table.
//
// Ports   :
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    he_lut_remap_if.slave (table stream, pixel stream, output stream,
//          ready, line_end, frame_done, mono_err)
//
// Parameters:
//   IMAGE_WIDTH   pixels per line   (default 660)
//   IMAGE_HEIGHT  lines per frame   (default 440)
//
// Optional feature:
//   HE_LUT_MONO_CHECK_EN  when defined, a table entry smaller than its
//                         predecessor sets the sticky mono_err flag. When
//                         undefined, mono_err is tied low.
// -----------------------------------------------------------------------------
module he_lut_remap #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440
) (
  input  logic          clk,
  input  logic          reset,
  he_lut_remap_if.slave bus
);

  localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam logic [9:0]  LAST_COL = 10'(IMAGE_WIDTH - 1);
  localparam logic [18:0] LAST_PIX = 19'(NUM_PIXELS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_MAP  = 2'd2;

  // Control state
  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q,   idx_d;
  logic [9:0]  col_q,   col_d;
  logic [18:0] pix_q,   pix_d;

  // Output registers
  logic        out_vld_q;
  logic [7:0]  pixel_out_q;
  logic        line_end_q;
  logic        frame_done_q;

  // Table storage; never reset so a table survives a reset pulse
  logic [7:0]  lut_q [256];

  // Per-cycle decode
  logic        lut_we;
  logic [7:0]  lut_wa;
  logic        accept;
  logic        last_col;
  logic        last_pix;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    col_d    = col_q;
    pix_d    = pix_q;
    lut_we   = 1'b0;
    lut_wa   = idx_q;
    accept   = 1'b0;
    last_col = 1'b0;
    last_pix = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // First entry goes to address 0 regardless of the stale index
        if (bus.tbl_valid) begin
          lut_we  = 1'b1;
          lut_wa  = 8'd0;
          idx_d   = 8'd1;
          col_d   = 10'd0;
          pix_d   = 19'd0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (bus.tbl_valid) begin
          lut_we = 1'b1;
          idx_d  = idx_q + 8'd1;
          if (idx_q == 8'd255) begin
            state_d = ST_MAP;
          end
        end
      end

      ST_MAP: begin
        if (bus.pixel_valid) begin
          accept   = 1'b1;
          last_col = (col_q == LAST_COL);
          last_pix = (pix_q == LAST_PIX);
          col_d    = last_col ? 10'd0 : col_q + 10'd1;
          pix_d    = pix_q + 19'd1;
          // Counters are cleared as the FSM re-enters IDLE
          if (last_pix) begin
            col_d   = 10'd0;
            pix_d   = 19'd0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage boundary: control state and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'd0;
      col_q        <= 10'd0;
      pix_q        <= 19'd0;
      out_vld_q    <= 1'b0;
      pixel_out_q  <= 8'h00;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
      out_vld_q    <= accept;
      line_end_q   <= accept & (last_col | last_pix);
      frame_done_q <= accept & last_pix;
      if (accept) begin
        pixel_out_q <= lut_q[bus.pixel_in];
      end
    end
  end

  // Table write port; reads only happen in MAP so there is no read/write overlap
  always_ff @(posedge clk) begin
    if (!reset && lut_we) begin
      lut_q[lut_wa] <= bus.tbl_data;
    end
  end

`ifdef HE_LUT_MONO_CHECK_EN
  logic [7:0] prev_q;
  logic       mono_q;

  // Last written entry, used as the comparison reference for the next one
  always_ff @(posedge clk) begin
    if (lut_we) begin
      prev_q <= bus.tbl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mono_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.tbl_valid) begin
      mono_q <= 1'b0;
    end else if (state_q == ST_LOAD && bus.tbl_valid && (bus.tbl_data < prev_q)) begin
      mono_q <= 1'b1;
    end
  end

  assign bus.mono_err = mono_q;
`else
  assign bus.mono_err = 1'b0;
`endif

  assign bus.ready           = (state_q == ST_MAP);
  assign bus.pixel_out_valid = out_vld_q;
  assign bus.pixel_out       = pixel_out_q;
  assign bus.line_end        = line_end_q;
  assign bus.frame_done      = frame_done_q;

endmodule

// File: tb/tb_he_lut_remap.sv
module tb_he_lut_remap;
  localparam int W    = 16;
  localparam int H    = 20;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  he_lut_remap_if bus();

  he_lut_remap #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: table contents plus frame bookkeeping
  logic [7:0] ref_lut [256];
  int         n_loaded;
  int         pix_count;
  bit         mapping;
  bit         mono_m;
  bit         exp_valid;
  bit         exp_le;
  bit         exp_fd;
  logic [7:0] exp_out;

  int n_checks = 0;
  int n_errors = 0;
  int le_count = 0;
  int fd_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst_v, input bit tv, input logic [7:0] td,
                       input bit pv, input logic [7:0] pi);
    reset           = rst_v;
    bus.tbl_valid   = tv;
    bus.tbl_data    = td;
    bus.pixel_valid = pv;
    bus.pixel_in    = pi;
    @(posedge clk);
    if (rst_v) begin
      mapping   = 0;
      n_loaded  = 0;
      pix_count = 0;
      exp_valid = 0;
      exp_le    = 0;
      exp_fd    = 0;
      exp_out   = 8'h00;
      mono_m    = 0;
    end else begin
      exp_valid = 0;
      exp_le    = 0;
      exp_fd    = 0;
      if (!mapping) begin
        if (tv) begin
          if (n_loaded == 0) mono_m = 0;
          else if (td < ref_lut[n_loaded-1]) mono_m = 1;
          ref_lut[n_loaded] = td;
          n_loaded++;
          if (n_loaded == 256) begin
            mapping  = 1;
            n_loaded = 0;
          end
        end
      end else if (pv) begin
        exp_out   = ref_lut[pi];
        exp_valid = 1;
        pix_count++;
        exp_le    = (pix_count % W) == 0;
        exp_fd    = (pix_count == NPIX);
        if (exp_fd) begin
          mapping   = 0;
          pix_count = 0;
        end
      end
    end
    #1;
    check("ready",      32'(bus.ready),           32'(mapping));
    check("out_valid",  32'(bus.pixel_out_valid), 32'(exp_valid));
    check("pixel_out",  32'(bus.pixel_out),       32'(exp_out));
    check("line_end",   32'(bus.line_end),        32'(exp_le));
    check("frame_done", 32'(bus.frame_done),      32'(exp_fd));
`ifdef HE_LUT_MONO_CHECK_EN
    check("mono_err",   32'(bus.mono_err),        32'(mono_m));
`else
    check("mono_err",   32'(bus.mono_err),        32'd0);
`endif
    if (bus.line_end)   le_count++;
    if (bus.frame_done) fd_count++;
  endtask

  // Random mapping traffic (with ignored table traffic) until the frame ends
  task automatic finish_frame();
    for (int n = 0; n < 4 * NPIX && mapping; n++) begin
      cycle(0, 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 3) != 0), 8'($urandom));
    end
  endtask

  initial begin
    logic [7:0] v;
    int k;
    reset           = 1'b1;
    bus.tbl_valid   = 1'b0;
    bus.tbl_data    = 8'h00;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = 8'h00;

    // Reset state
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(1, 1, 8'h55, 1, 8'h12);

    // Identity table, contiguous load, then stream 0..255
    for (int i = 0; i < 256; i++) cycle(0, 1, 8'(i), 0, 8'h00);
    le_count = 0;
    fd_count = 0;
    for (int i = 0; i < 256; i++) cycle(0, 0, 8'h00, 1, 8'(i));
    finish_frame();
    cycle(0, 0, 8'h00, 0, 8'h00);
    check("line_end_count",   32'(le_count), 32'(H));
    check("frame_done_count", 32'(fd_count), 32'd1);
    check("ready_after_frame", 32'(bus.ready), 32'd0);

    // Inverted table with gaps; pixels offered during the load are ignored
    k = 0;
    while (k < 256) begin
      if (k % 2 == 0 || $urandom_range(0, 1) == 0) begin
        cycle(0, 1, 8'(255 - k), 1, 8'h10);
        k++;
      end
      cycle(0, 0, 8'h00, 1, 8'h10);
    end
    check("remap_10", 32'(bus.pixel_out), 32'h0000_00EF);
    for (int i = 0; i < 30; i++) cycle(0, 0, 8'h00, 1'($urandom_range(0, 1)), 8'($urandom));
    // Reset while an output is in flight
    cycle(0, 0, 8'h00, 1, 8'h42);
    cycle(1, 0, 8'h00, 1, 8'h43);
    cycle(1, 0, 8'h00, 0, 8'h00);

    // Partial load discarded by reset, then a full random table
    for (int i = 0; i < 100; i++) cycle(0, 1, 8'($urandom), 0, 8'h00);
    cycle(1, 1, 8'h00, 0, 8'h00);
    cycle(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 256; i++)
      cycle(0, 1'($urandom_range(0, 3) != 0) | 1'b1, 8'($urandom), 1, 8'($urandom));
    finish_frame();

    // Monotonic table except a single dip at entry 50
    for (int i = 0; i < 256; i++) begin
      v = (i == 49) ? 8'h30 : (i == 50) ? 8'h20 : 8'(i);
      cycle(0, 1, v, 0, 8'h00);
    end
    for (int i = 0; i < 40; i++) cycle(0, 0, 8'h00, 1, 8'($urandom));
    finish_frame();
    // A new load clears the sticky flag
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'(i * 3), 0, 8'h00);
    cycle(1, 0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
